muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 145 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO register file with a fixed-latency multiplier and a
// radix-2 restoring divider (32 iterations plus one sign-fixup cycle).
module muldiv_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    input  logic        rd_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, SIGN} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic        sgn_q;        // op is a signed variant (MULT / DIV)
    logic [31:0] a_q, b_q;     // raw operands, kept for product and sign fixup
    logic [31:0] dvs;          // divisor magnitude
    logic [31:0] quo;          // dividend shifts out the top, quotient shifts in
    logic [31:0] rem;

    logic        sgn_in;
    logic [31:0] a_mag, b_mag;
    logic [63:0] ma, mb, prod;
    logic [32:0] rem_sh;
    logic [31:0] diff;
    logic        ge;
    logic        neg_q, neg_r;
    logic [31:0] lo_fix, hi_fix;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = op[1] ? DIV : MUL;
            MUL:  if (cnt == 5'd0) state_nxt = IDLE;
            DIV:  if (cnt == 5'd0) state_nxt = SIGN;
            SIGN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign stall = busy & (start | rd_req | wr_hi | wr_lo);

    // Operand conditioning, product, divider step and final sign fixup
    always_comb begin
        sgn_in = ~op[0];
        a_mag  = (sgn_in & a[31]) ? (32'd0 - a) : a;
        b_mag  = (sgn_in & b[31]) ? (32'd0 - b) : b;

        // Sign-extend to 64 bits; the low 64 bits of the product are exact
        // for both signed and unsigned interpretations.
        ma   = {{32{sgn_q & a_q[31]}}, a_q};
        mb   = {{32{sgn_q & b_q[31]}}, b_q};
        prod = ma * mb;

        rem_sh = {rem, quo[31]};
        ge     = (rem_sh >= {1'b0, dvs});
        diff   = rem_sh[31:0] - dvs;

        neg_q = sgn_q & (a_q[31] ^ b_q[31]);
        neg_r = sgn_q & a_q[31];
        if (b_q == 32'd0) begin
            // Divide by zero: all-ones quotient, dividend passed through.
            lo_fix = 32'hFFFF_FFFF;
            hi_fix = a_q;
        end else begin
            lo_fix = neg_q ? (32'd0 - quo) : quo;
            hi_fix = neg_r ? (32'd0 - rem) : rem;
        end
    end

    // Datapath: operand capture, iteration, HI/LO update and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            hi    <= 32'd0;
            lo    <= 32'd0;
            done  <= 1'b0;
            cnt   <= 5'd0;
            sgn_q <= 1'b0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            dvs   <= 32'd0;
            quo   <= 32'd0;
            rem   <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sgn_q <= sgn_in;
                        a_q   <= a;
                        b_q   <= b;
                        dvs   <= b_mag;
                        quo   <= a_mag;
                        rem   <= 32'd0;
                        cnt   <= op[1] ? 5'd31 : 5'(MUL_LAT - 1);
                    end else begin
                        if (wr_hi) hi <= wdata;
                        if (wr_lo) lo <= wdata;
                    end
                end
                MUL: begin
                    if (cnt == 5'd0) begin
                        hi   <= prod[63:32];
                        lo   <= prod[31:0];
                        done <= 1'b1;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                DIV: begin
                    rem <= ge ? diff : rem_sh[31:0];
                    quo <= {quo[30:0], ge};
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                SIGN: begin
                    hi   <= hi_fix;
                    lo   <= lo_fix;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: each op pushes its expected HI/LO and
// completion cycle; a forked monitor pops on every done pulse.
module tb_muldiv_ctrl;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset, start, wr_hi, wr_lo, rd_req;
    logic [1:0]  op;
    logic [31:0] a, b, wdata, hi, lo;
    logic        busy, stall, done;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    muldiv_ctrl #(.MUL_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .rd_req(rd_req),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Issue one op at a negedge, push its expectation, count busy cycles.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi,
                          input logic [31:0] elo, input int lat);
        exp_t e;
        int n;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        e.hi = ehi; e.lo = elo; e.cyc = cyc + 1 + lat;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_busy_cycles"}, n, lat);
    endtask

    initial begin
        exp_t e;
        int n;
        reset = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; rd_req = 1'b0;
        op = 2'd0; a = 32'd0; b = 32'd0; wdata = 32'd0;

        fork
            forever begin
                @(negedge clk);
                if (done === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done at cycle %0d hi %h lo %h", cyc, hi, lo);
                    end else begin
                        e = exp_q.pop_front();
                        if (hi !== e.hi || lo !== e.lo || cyc != e.cyc) begin
                            errors++;
                            $display("FAIL result got hi %h lo %h cyc %0d want hi %h lo %h cyc %0d",
                                     hi, lo, cyc, e.hi, e.lo, e.cyc);
                        end
                    end
                end
            end
        join_none

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);

        run_op("mult_neg",  2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, LAT);
        run_op("multu",     2'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, LAT);
        run_op("mult_min",  2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, LAT);
        run_op("div_neg",   2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("div_negb",  2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33);
        run_op("divu",      2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_op("divu_zero", 2'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 33);
        run_op("div_zero",  2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 33);
        run_op("div_ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);

        // MTHI/MTLO together in IDLE
        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hCAFE_0001;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        chk("mt_both_hi", hi, 32'hCAFE_0001);
        chk("mt_both_lo", lo, 32'hCAFE_0001);
        wr_lo = 1'b1; wdata = 32'h0000_AAAA;
        @(negedge clk);
        wr_lo = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_AAAA);
        chk("mtlo_hi_kept", hi, 32'hCAFE_0001);

        // start with wr_lo: write ignored, lo held until completion
        op = 2'd1; a = 32'd2; b = 32'd3; start = 1'b1; wr_lo = 1'b1; wdata = 32'h0000_5555;
        e.hi = 32'd0; e.lo = 32'd6; e.cyc = cyc + 1 + LAT;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        chk("start_wrlo_lo_held", lo, 32'h0000_AAAA);
        @(negedge clk);
        chk("midop_hi_held", hi, 32'hCAFE_0001);
        repeat (3) @(negedge clk);

        // Stall during DIVU with rd_req and a queued second start
        op = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        e.hi = 32'd2; e.lo = 32'd14; e.cyc = cyc + 34;
        exp_q.push_back(e);
        @(negedge clk);
        op = 2'd1; a = 32'd4; b = 32'd5; rd_req = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            #1;
            if (stall !== 1'b1) begin
                checks++; errors++;
                $display("FAIL stall_busy got %b want 1 at cycle %0d", stall, cyc);
            end
            n++;
            @(negedge clk);
        end
        chk("stall_busy_cycles", n, 33);
        e.hi = 32'd0; e.lo = 32'd20; e.cyc = cyc + 1 + LAT;
        exp_q.push_back(e);
        #1;
        chk("stall_after_sign", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; rd_req = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        // Reset ten cycles into a DIV
        op = 2'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        wr_hi = 1'b1; wdata = 32'h0000_1234;
        @(negedge clk);
        wr_hi = 1'b0;
        chk("mthi_after_rst", hi, 32'h0000_1234);
        chk("mthi_done", {31'd0, done}, 32'd0);
        repeat (40) @(negedge clk);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
